// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan path: active-low segment fonts and digit enables.
package fnd_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = 2'd3;

  // Segment order {dp,g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [7:0] FONT_0    = 8'hC0;
  localparam logic [7:0] FONT_1    = 8'hF9;
  localparam logic [7:0] FONT_2    = 8'hA4;
  localparam logic [7:0] FONT_3    = 8'hB0;
  localparam logic [7:0] FONT_4    = 8'h99;
  localparam logic [7:0] FONT_5    = 8'h92;
  localparam logic [7:0] FONT_6    = 8'h82;
  localparam logic [7:0] FONT_7    = 8'hF8;
  localparam logic [7:0] FONT_8    = 8'h80;
  localparam logic [7:0] FONT_9    = 8'h90;
  localparam logic [7:0] FONT_DASH = 8'hBF;
  localparam logic [7:0] FONT_OFF  = 8'hFF;

  localparam logic [3:0] DIGIT_OFF = 4'b1111;

  // Element [i] is the enable pattern for digit index i.
  localparam logic [3:0][3:0] DIGIT_EN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/fnd_bcd_to_font.sv
// Combinational BCD nibble to active-low seven-segment font; non-BCD codes show a dash.
module fnd_bcd_to_font
  import fnd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_font
);

  always_comb begin
    o_font = FONT_DASH;
    case (i_nibble)
      4'd0: o_font = FONT_0;
      4'd1: o_font = FONT_1;
      4'd2: o_font = FONT_2;
      4'd3: o_font = FONT_3;
      4'd4: o_font = FONT_4;
      4'd5: o_font = FONT_5;
      4'd6: o_font = FONT_6;
      4'd7: o_font = FONT_7;
      4'd8: o_font = FONT_8;
      4'd9: o_font = FONT_9;
      default: o_font = FONT_DASH;
    endcase
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scanner with per-frame snapshot and leading-zero blanking.
// Defining FND_DECIMAL_POINT_EN adds the i_dp per-digit decimal point input.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int P_SCAN_DIV = 100000,
  parameter int P_LZB      = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
`ifdef FND_DECIMAL_POINT_EN
  input  logic [3:0]  i_dp,
`endif
  input  logic        i_blank,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_digit,
  output logic [7:0]  o_font,
  output logic        o_frame_tick
);

  localparam int CW = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(P_SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    digit_q, digit_d;
  logic [7:0]    font_q, font_d;
  logic          tick_q, tick_d;
  logic [3:0]    dp_sel;

  logic          slot_tick;
  logic          frame_wrap;
  logic [3:0]    cur_nibble;
  logic [7:0]    font_raw;
  logic [3:0]    nib_zero;
  logic [3:0]    lz_mask;
  logic          digit_off;

`ifdef FND_DECIMAL_POINT_EN
  logic [3:0] dp_q, dp_d;

  always_comb begin
    dp_d = frame_wrap ? i_dp : dp_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) dp_q <= 4'b0000;
    else         dp_q <= dp_d;
  end

  assign dp_sel = dp_q;
`else
  assign dp_sel = 4'b0000;
`endif

  assign slot_tick  = (cnt_q == CNT_LAST);
  assign frame_wrap = slot_tick && (idx_q == LAST_DIGIT);
  assign cur_nibble = snap_q[{idx_q, 2'b00} +: 4];

  fnd_bcd_to_font u_font (
    .i_nibble (cur_nibble),
    .o_font   (font_raw)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nib_zero[k] = (snap_q[4*k +: 4] == 4'h0);
    end
  end

  // A digit is leading-zero blanked only if it and all more-significant nibbles are zero.
  always_comb begin
    lz_mask = 4'b0000;
    if (P_LZB != 0) begin
      lz_mask[3] = nib_zero[3] & ~dp_sel[3];
      lz_mask[2] = nib_zero[3] & nib_zero[2] & ~dp_sel[2];
      lz_mask[1] = nib_zero[3] & nib_zero[2] & nib_zero[1] & ~dp_sel[1];
    end
  end

  always_comb begin
    cnt_d     = slot_tick ? '0 : cnt_q + CW'(1);
    idx_d     = slot_tick ? idx_q + 2'd1 : idx_q;
    snap_d    = frame_wrap ? i_bcd : snap_q;
    tick_d    = frame_wrap;
    digit_off = i_blank | lz_mask[idx_q];
    digit_d   = DIGIT_EN[idx_q];
    font_d    = {font_raw[7] & ~dp_sel[idx_q], font_raw[6:0]};
    if (digit_off) begin
      digit_d = DIGIT_OFF;
      font_d  = FONT_OFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      digit_q <= DIGIT_OFF;
      font_q  <= FONT_OFF;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      digit_q <= digit_d;
      font_q  <= font_d;
      tick_q  <= tick_d;
    end
  end

  assign o_digitSelect = idx_q;
  assign o_digit       = digit_q;
  assign o_font        = font_q;
  assign o_frame_tick  = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: reference model pushes per-edge expectations, monitor compares.
module tb_fnd_scan_controller;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'h0000;
  logic        blank = 1'b0;
  logic [3:0]  dp = 4'b0000;

  logic [1:0] a_sel, b_sel;
  logic [3:0] a_dig, b_dig;
  logic [7:0] a_font, b_font;
  logic       a_tick, b_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.P_SCAN_DIV(DIV), .P_LZB(1)) dut_a (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_bcd         (bcd),
`ifdef FND_DECIMAL_POINT_EN
    .i_dp          (dp),
`endif
    .i_blank       (blank),
    .o_digitSelect (a_sel),
    .o_digit       (a_dig),
    .o_font        (a_font),
    .o_frame_tick  (a_tick)
  );

  fnd_scan_controller #(.P_SCAN_DIV(DIV), .P_LZB(0)) dut_b (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_bcd         (bcd),
`ifdef FND_DECIMAL_POINT_EN
    .i_dp          (dp),
`endif
    .i_blank       (blank),
    .o_digitSelect (b_sel),
    .o_digit       (b_dig),
    .o_font        (b_font),
    .o_frame_tick  (b_tick)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] dig_a;
    logic [7:0] font_a;
    logic [3:0] dig_b;
    logic [7:0] font_b;
    logic       tick;
  } exp_t;

  exp_t q[$];

  function automatic logic [7:0] font_of(input logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // What the pins should show for digit idx given the frame's snapshot.
  function automatic void shown(input int idx, input logic [15:0] s, input logic [3:0] d,
                                input logic blk, input bit lzb,
                                output logic [3:0] dig, output logic [7:0] f);
    bit off;
    bit allz;
    off  = blk;
    allz = 1'b1;
    if (lzb && idx > 0) begin
      for (int k = idx; k < 4; k++) if (s[4*k +: 4] != 4'h0) allz = 1'b0;
      if (allz && !d[idx]) off = 1'b1;
    end
    f = font_of(s[4*idx +: 4]);
`ifdef FND_DECIMAL_POINT_EN
    f[7] = ~d[idx];
`endif
    dig = ~(4'b0001 << idx);
    if (off) begin
      dig = 4'hF;
      f   = 8'hFF;
    end
  endfunction

  // Reference: n counts clock edges since reset; slot = n/DIV, digit = slot mod 4.
  int          n = 0;
  logic [15:0] m_snap = 16'h0000;
  logic [3:0]  m_dp = 4'b0000;
  exp_t        m_e;
  int          m_idx;

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      m_snap = 16'h0000;
      m_dp = 4'b0000;
      m_e = '{sel: 2'd0, dig_a: 4'hF, font_a: 8'hFF, dig_b: 4'hF, font_b: 8'hFF, tick: 1'b0};
    end else begin
      m_idx = (n / DIV) % 4;
      shown(m_idx, m_snap, m_dp, blank, 1'b1, m_e.dig_a, m_e.font_a);
      shown(m_idx, m_snap, m_dp, blank, 1'b0, m_e.dig_b, m_e.font_b);
      if ((n % DIV) == DIV - 1 && m_idx == 3) begin
        m_snap = bcd;
        m_dp = dp;
      end
      n = n + 1;
      m_e.sel  = 2'((n / DIV) % 4);
      m_e.tick = ((n % (4 * DIV)) == 0);
    end
    q.push_back(m_e);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, expv);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("sel_a",  {6'd0, a_sel},  {6'd0, mon_e.sel});
      chk("dig_a",  {4'd0, a_dig},  {4'd0, mon_e.dig_a});
      chk("font_a", a_font,         mon_e.font_a);
      chk("tick_a", {7'd0, a_tick}, {7'd0, mon_e.tick});
      chk("sel_b",  {6'd0, b_sel},  {6'd0, mon_e.sel});
      chk("dig_b",  {4'd0, b_dig},  {4'd0, mon_e.dig_b});
      chk("font_b", b_font,         mon_e.font_b);
      chk("tick_b", {7'd0, b_tick}, {7'd0, mon_e.tick});
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_sel(input logic [1:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (a_sel == v) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_sel timeout got %0d expected %0d", a_sel, v);
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    int c;
    r = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      c = $urandom_range(0, 9);
      if (c < 4)      r[4*k +: 4] = 4'h0;
      else if (c < 9) r[4*k +: 4] = 4'($urandom_range(1, 9));
      else            r[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    bcd = 16'h1234;
    cyc(48);
    bcd = 16'h0007;
    cyc(40);
    bcd = 16'h1234;
    cyc(20);
    wait_sel(2'd1);
    bcd = 16'h5678;
    cyc(40);
    bcd = 16'h00A0;
    cyc(24);
    blank = 1'b1;
    cyc(10);
    blank = 1'b0;
    cyc(20);
    wait_sel(2'd2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bcd = 16'h0000;
`ifdef FND_DECIMAL_POINT_EN
    dp = 4'b0010;
`endif
    cyc(40);
    repeat (30) begin
      bcd = rand_bcd();
`ifdef FND_DECIMAL_POINT_EN
      dp = 4'($urandom_range(0, 15));
`endif
      blank = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 12) == 0);
      cyc($urandom_range(1, 30));
      rst = 1'b0;
      cyc($urandom_range(1, 20));
    end
    blank = 1'b0;
    cyc(20);
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
